// File: rtl/pll_phase_step_ctrl.sv
// Initiator for the PLL dynamic-phase-shift port: steps one counter N times,
// pacing each step on the PLL's phase_done handshake, in the scanclk domain.
module pll_phase_step_ctrl #(
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int STEP_W         = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              scanclk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_cntsel,
  input  logic              cmd_updn,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              pll_locked,
  output logic              phase_en,
  output logic              updn,
  output logic [4:0]        cntsel,
  input  logic              phase_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [STEP_W-1:0] steps_done,
  output logic [2:0]        state_dbg
);

  localparam int TMAX = (TIMEOUT_CYCLES > PULSE_CYCLES) ? TIMEOUT_CYCLES : PULSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_PULSE     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // phase_done idles high, so its synchroniser resets high to avoid a false edge.
  logic [SYNC_STAGES-1:0] phase_done_sync;
  logic [SYNC_STAGES-1:0] locked_sync;
  logic                   phase_done_s;
  logic                   locked_s;

  always_ff @(posedge scanclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      phase_done_sync <= '1;
      locked_sync     <= '0;
    end else begin
      phase_done_sync <= {phase_done_sync[SYNC_STAGES-2:0], phase_done};
      locked_sync     <= {locked_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign phase_done_s = phase_done_sync[SYNC_STAGES-1];
  assign locked_s     = locked_sync[SYNC_STAGES-1];

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [STEP_W-1:0]   count_q;
  logic [STEP_W-1:0]   steps_done_q;
  logic [4:0]          cntsel_q;
  logic                updn_q;
  logic                error_q;
  logic                phase_en_q;
  logic                accept;
  logic                set_error;
  logic                step_inc;
  logic                active;

  assign cmd_ready = rst_int_n && (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign active    = (state_q == S_SETUP) || (state_q == S_PULSE) ||
                     (state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH);

  always_ff @(posedge scanclk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    set_error = 1'b0;
    step_inc  = 1'b0;
    if (active && !locked_s) begin
      state_d   = S_DONE;
      set_error = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if ((cmd_cntsel > 5'd19) || !locked_s) begin
              state_d   = S_DONE;
              set_error = 1'b1;
            end else if (cmd_steps == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SETUP;
            end
          end
        end
        S_SETUP: state_d = S_PULSE;
        S_PULSE: begin
          if (timer_q == PULSE_LAST) state_d = S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!phase_done_s) begin
            state_d = S_WAIT_HIGH;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d   = S_DONE;
            set_error = 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (phase_done_s) begin
            step_inc = 1'b1;
            state_d  = (steps_done_q == count_q - STEP_W'(1)) ? S_DONE : S_SETUP;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d   = S_DONE;
            set_error = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // One timer serves the pulse width and both handshake timeouts; it restarts on every state change.
  always_comb begin
    timer_d = timer_q + TW'(1);
    if ((state_d != state_q) || (state_q == S_IDLE)) timer_d = '0;
  end

  always_ff @(posedge scanclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      timer_q      <= '0;
      count_q      <= '0;
      steps_done_q <= '0;
      cntsel_q     <= '0;
      updn_q       <= 1'b0;
      error_q      <= 1'b0;
      phase_en_q   <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      phase_en_q <= (state_d == S_PULSE);
      if (accept) begin
        cntsel_q     <= cmd_cntsel;
        updn_q       <= cmd_updn;
        count_q      <= cmd_steps;
        steps_done_q <= '0;
        error_q      <= set_error;
      end else begin
        if (set_error) error_q <= 1'b1;
        if (step_inc && (steps_done_q != count_q)) steps_done_q <= steps_done_q + STEP_W'(1);
      end
    end
  end

  assign phase_en   = phase_en_q;
  assign updn       = updn_q;
  assign cntsel     = cntsel_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign steps_done = steps_done_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/pll_phase_step_ctrl.md
Name: pll_phase_step_ctrl

Overview:
- Initiator side of the PLL dynamic-phase-shift (DPS) interface.
- Accepts a command of the form "shift counter X by N steps, up or down".
- Drives cntsel/updn/phase_en toward the PLL's DPS port and paces each step on the PLL's phase_done handshake.
- Reports progress, completion and timeout/lock errors. Sits beside the DPA PLL in the scanclk domain and is commanded by the link-alignment logic.

Parameters:
- PULSE_CYCLES, 2, scanclk cycles phase_en is held high per step (min 2).
- TIMEOUT_CYCLES, 1023, max cycles to wait for each phase_done edge before error.
- STEP_W, 8, width of the step count and progress counter.
- SYNC_STAGES, 2, flops on the phase_done and pll_locked synchronisers (min 2).

Ports:
- scanclk  in  1  DPS clock; all logic is rising-edge in this domain.
- rst_n  in  1  asynchronous active-low reset, synchronous deassertion internally.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_cntsel  in  5  counter select: 0..17 selects C0..C17, 18 selects all C, 19 selects M.
- cmd_updn  in  1  1 = shift up (later), 0 = shift down.
- cmd_steps  in  STEP_W  number of phase steps.
- pll_locked  in  1  PLL locked, asynchronous; synchronised internally.
- phase_en  out  1  to PLL.
- updn  out  1  to PLL.
- cntsel  out  5  to PLL.
- phase_done  in  1  from PLL, asynchronous; synchronised internally.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of every accepted command.
- error  out  1  sticky; cleared by the next accepted command.
- steps_done  out  STEP_W  steps completed in the current or last command.

Behaviour:
- Reset values:
  - phase_en=0, updn=0, cntsel=0.
  - busy=0, done=0, error=0, steps_done=0.
  - cmd_ready=1 once reset has deasserted.
  - State = IDLE.
  - Synchroniser flops reset to 1 for phase_done and 0 for pll_locked.
- Latch at acceptance: cmd_cntsel, cmd_updn, cmd_steps are registered; cntsel/updn outputs update on the acceptance edge and stay stable until the next acceptance.
- IDLE -> SETUP on acceptance, but only if all of the following hold:
  - cmd_steps != 0;
  - cmd_cntsel <= 19;
  - synchronised locked = 1.
- Zero-step command:
  - cmd_steps == 0 -> DONE, with no phase_en activity and error unchanged (cleared).
- Rejected command:
  - cmd_cntsel > 19, or locked = 0 at acceptance -> error=1, then DONE.
  - No phase_en activity.
- SETUP: one cycle with phase_en=0 for cntsel/updn setup -> PULSE.
- PULSE: phase_en=1 for exactly PULSE_CYCLES cycles -> WAIT_LOW.
- WAIT_LOW: wait for synchronised phase_done = 0 -> WAIT_HIGH.
- WAIT_HIGH: wait for synchronised phase_done = 1, then increment steps_done.
  - steps_done == latched count -> DONE.
  - Otherwise -> SETUP.
- Timeout:
  - A single timer counts cycles in WAIT_LOW and WAIT_HIGH and restarts at each state entry.
  - Reaching TIMEOUT_CYCLES -> error=1, then DONE.
  - steps_done keeps its value at the point of timeout.
- Lock loss:
  - Synchronised locked falling to 0 in SETUP, PULSE, WAIT_LOW or WAIT_HIGH -> error=1, phase_en=0 immediately (registered, next edge), then DONE.
- DONE: done=1 for one cycle -> IDLE. Back-to-back commands cost at least one IDLE cycle.
- steps_done is cleared on acceptance and saturates at the latched count (no wrap). A maximum count of 2^STEP_W-1 must complete without overflow.
- phase_done already low on entry to WAIT_LOW (fast PLL) counts as the low edge; no extra wait.
- Asynchronous reset mid-operation: phase_en drops to 0 immediately; the command is abandoned and no done pulse is produced.
- cmd_valid while busy is ignored (cmd_ready=0); it is not queued.

Test Plan:
- Normal up-shift: model PLL drops phase_done 3 cycles after phase_en rises and restores it 4 cycles later; cmd C2, up, steps=3.
  - Required: exactly 3 phase_en pulses, each 2 cycles wide.
  - Required: cntsel=2, updn=1 throughout.
  - Required: steps_done=3, a single done pulse, error=0.
- Zero steps: cmd steps=0.
  - Required: no phase_en activity, done 1 cycle after acceptance, error=0, steps_done=0.
- Timeout: model never drops phase_done; TIMEOUT_CYCLES=16; cmd steps=5.
  - Required: error=1 and done about 16 cycles after the first pulse, steps_done=0.
  - Required: the next valid command clears error.
- Lock loss: pll_locked deasserted during step 2 of 4.
  - Required: phase_en low within SYNC_STAGES+1 cycles, error=1, steps_done=1, done pulse.
- Illegal select and backpressure: cmd cntsel=25 -> error=1, no pulses. Then cmd_valid held high while busy on a legal 2-step command -> only one acceptance, and cmd_ready=0 until return to IDLE.
- Max count and reset: steps=255 with a fast PLL model -> steps_done=255 with no wrap. Then reset asserted mid-run -> all outputs return to their reset values asynchronously.
